i2c_register_target: RTL and testbench
======================================

Name: i2c_register_target

Overview:
- Parametrised I2C target (slave) endpoint exposing a byte-addressed register bank to an external I2C master.
- Successor to the fixed single-purpose I2C endpoint: adds configurable device address, register count, input glitch filtering, multi-byte auto-increment transfers and repeated-START support.
- Sits between the board I2C pins (open-drain, tri-stated at top level) and the motor/diagnostics control logic in the system clock domain.

Parameters:
- DEVICE_ADDR, 7'h50, 7-bit I2C target address matched after START.
- NUM_REGS, 16, number of 8-bit registers; legal range 2..256.
- FILTER_LEN, 4, SCL/SDA glitch filter depth in clock cycles; legal range 1..15.
- AUTO_INC, 1, 1 = pointer increments after each data byte; 0 = pointer fixed.

Ports:
- Clk_ik  in  1  system clock; must be at least 8x the SCL rate.
- Rst_irn  in  1  asynchronous active-low reset.
- Scl_i  in  1  SCL pin sample, asynchronous.
- Sda_i  in  1  SDA pin sample, asynchronous.
- SdaOe_o  out  1  1 = pull SDA low; 0 = release. Top level builds the open-drain.
- RegsWr_ob  out  NUM_REGS*8  write register bank; register k occupies bits [8k+7:8k].
- RegsRd_ib  in  NUM_REGS*8  read bank; same byte layout, sampled when a read byte is loaded.
- WrStrobe_o  out  1  one-cycle pulse when a data byte is committed to RegsWr_ob.
- WrAddr_ob8  out  8  register index of the last committed write.
- Busy_o  out  1  1 from address match until STOP or NACK-terminated read.

Behaviour:
- Reset values: SdaOe_o=0, RegsWr_ob=0, WrStrobe_o=0, WrAddr_ob8=0, Busy_o=0, pointer=0, FSM=IDLE.
- Input conditioning: 2-flop synchroniser on each pin, then a majority-free filter. The filtered value changes only after FILTER_LEN consecutive identical samples.
- Edge detection runs on the filtered signals.
  - START/repeated START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
- START/STOP detection has priority in every state.
  - START from any state goes to ADDR, clears the bit counter and releases SDA.
  - STOP from any state goes to IDLE and clears Busy_o. The pointer is retained.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
  - Bits are sampled on the SCL rising edge. SDA is changed only on the SCL falling edge, one cycle after the filtered edge.
- ADDR: shift 8 bits (address MSB first, then R/W).
  - Match: go to ADDR_ACK, drive SDA low for one SCL period, set Busy_o.
  - Mismatch: go to IDLE with no ACK.
- After ADDR_ACK:
  - R/W=0: go to PTR.
  - R/W=1: go to RD with the byte RegsRd_ib[pointer] loaded on the ACK falling edge.
- PTR: receive 8 bits into the pointer, ACK in PTR_ACK, then go to WR.
  - A pointer value >= NUM_REGS is NACKed (SDA released) and the FSM goes to IDLE. The pointer is left unchanged.
- WR: receive a byte, then in WR_ACK:
  - Write it to RegsWr_ob[pointer].
  - Pulse WrStrobe_o exactly one Clk_ik cycle, on the SCL rising edge of the 8th bit.
  - Set WrAddr_ob8=pointer.
  - ACK the byte.
  - Pointer update: if AUTO_INC, pointer = (pointer+1) mod NUM_REGS, i.e. wraps from NUM_REGS-1 to 0.
- RD: shift the byte out MSB first. In RD_ACK, sample the master's ACK bit.
  - ACK=0: advance the pointer as in WR and load the next byte.
  - ACK=1 (NACK): release SDA and go to IDLE; Busy_o clears.
- Repeated START after PTR_ACK performs the standard register read. The pointer set in the write phase is kept.
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronous). SDA is released.
- SCL-stretching is not performed.

Optional Feature:
- Macro I2C_TARGET_DEBUG_EN.
- Defined: extra outputs
  - State_o: FSM state, encoding per the package's i2c_state_t.
  - AddrRx_ob8: last received address+R/W byte.
  - PtrRx_ob8: last received pointer byte.
  - Each updates on the corresponding ACK phase; all reset to 0.
- Undefined: these ports and their registers are absent. Functional behaviour is identical.

Test Plan:
- Write 0xA5 to register 3 at 100 kHz: START, 0xA0, 0x03, 0xA5, STOP.
  - Expect 3 ACKs and RegsWr_ob[31:24]=0xA5.
  - Expect one WrStrobe_o pulse with WrAddr_ob8=3, then Busy_o=0.
- Burst write at pointer 14, NUM_REGS=16, bytes 0x11,0x22,0x33.
  - Expect regs 14=0x11, 15=0x22, 0=0x33 (wrap) and three strobes.
- Repeated-START read: write pointer 5, RESTART 0xA1, read 2 bytes with ACK then NACK, with RegsRd_ib regs 5/6 = 0x5C/0x6D.
  - Expect master sees 0x5C, 0x6D; SDA released after NACK.
- Address 0x51 (0xA2): expect no ACK, SdaOe_o stays 0, no register changes.
- Pointer 0x20 with NUM_REGS=16: expect NACK on the pointer byte and no write.
- Robustness:
  - 2-cycle glitches on SCL with FILTER_LEN=4: expect no bit shift.
  - Rst_irn pulled low mid-read: expect SdaOe_o=0 and RegsWr_ob=0 immediately.

Source files
------------

// File: rtl/i2c_register_target.sv
// I2C target exposing a byte-addressed register bank; filtered SCL/SDA, auto-increment, repeated START.
// Optional debug outputs (State_o, AddrRx_ob8, PtrRx_ob8) exist only when I2C_TARGET_DEBUG_EN is defined.
package i2c_register_target_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    PTR_ACK  = 4'd4,
    WR       = 4'd5,
    WR_ACK   = 4'd6,
    RD       = 4'd7,
    RD_ACK   = 4'd8
  } i2c_state_t;
endpackage

module i2c_register_target
  import i2c_register_target_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         FILTER_LEN  = 4,
  parameter int         AUTO_INC    = 1
) (
  input  logic                  Clk_ik,
  input  logic                  Rst_irn,
  input  logic                  Scl_i,
  input  logic                  Sda_i,
  output logic                  SdaOe_o,
  output logic [NUM_REGS*8-1:0] RegsWr_ob,
  input  logic [NUM_REGS*8-1:0] RegsRd_ib,
  output logic                  WrStrobe_o,
  output logic [7:0]            WrAddr_ob8,
  output logic                  Busy_o
`ifdef I2C_TARGET_DEBUG_EN
  ,
  output i2c_state_t            State_o,
  output logic [7:0]            AddrRx_ob8,
  output logic [7:0]            PtrRx_ob8
`endif
);
  localparam int              PW    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]      FLOAD = 4'(FILTER_LEN - 1);
  localparam logic [7:0]      LAST  = 8'(NUM_REGS - 1);
  localparam logic [8:0]      NREG9 = 9'(NUM_REGS);

  // bit 0 = SCL, bit 1 = SDA; idle bus is high
  logic [1:0] meta_q, sync_q, filt_q, prev_q;
  logic [3:0] fcnt_q [2];

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= FLOAD;
    end else begin
      meta_q <= {Sda_i, Scl_i};
      sync_q <= meta_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          fcnt_q[i] <= FLOAD;
        end else if (fcnt_q[i] == 4'd0) begin
          filt_q[i] <= sync_q[i];
          fcnt_q[i] <= FLOAD;
        end else begin
          fcnt_q[i] <= fcnt_q[i] - 4'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  = scl_f & ~prev_q[0];
  assign scl_fall  = ~scl_f & prev_q[0];
  assign start_det = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
  assign stop_det  = scl_f & prev_q[0] & ~prev_q[1] & sda_f;

  i2c_state_t                 state_q, state_d;
  logic [2:0]                 bitcnt_q, bitcnt_d;
  logic [7:0]                 shift_q, shift_d;
  logic [7:0]                 ptr_q, ptr_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0][7:0]   rd_bank;
  logic                       sda_oe_q, sda_oe_d, busy_q, busy_d, strobe_q, strobe_d;
  logic                       phase_q, phase_d, rw_q, rw_d;
  logic [7:0]                 wr_addr_q, wr_addr_d;
  logic [7:0]                 rx_byte, ptr_inc, ptr_adv;
  logic [PW-1:0]              ptr_idx;
  logic                       addr_match, ptr_ok;

  assign rd_bank    = RegsRd_ib;
  assign rx_byte    = {shift_q[6:0], sda_f};
  assign ptr_idx    = ptr_q[PW-1:0];
  assign ptr_inc    = (ptr_q == LAST) ? 8'd0 : ptr_q + 8'd1;
  assign ptr_adv    = (AUTO_INC != 0) ? ptr_inc : ptr_q;
  assign addr_match = (rx_byte[7:1] == DEVICE_ADDR);
  assign ptr_ok     = ({1'b0, rx_byte} < NREG9);

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      regs_q    <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      phase_q   <= 1'b0;
      rw_q      <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      regs_q    <= regs_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // ACK states: first SCL fall drives/releases SDA, rise sets phase, second fall leaves
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    regs_d    = regs_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    phase_d   = phase_q;
    rw_d      = rw_q;
    wr_addr_d = wr_addr_q;
    if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      phase_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      phase_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (state_q == ADDR) begin
                if (addr_match) begin
                  state_d = ADDR_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end else if (state_q == PTR) begin
                if (ptr_ok) begin
                  state_d = PTR_ACK;
                  ptr_d   = rx_byte;
                end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end
              end else begin
                state_d         = WR_ACK;
                regs_d[ptr_idx] = rx_byte;
                strobe_d        = 1'b1;
                wr_addr_d       = ptr_q;
                ptr_d           = ptr_adv;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_rise) begin
            phase_d = 1'b1;
          end else if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
            end else begin
              phase_d  = 1'b0;
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d  = RD;
                shift_d  = rd_bank[ptr_idx];
                sda_oe_d = ~rd_bank[ptr_idx][7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WR;
              end
            end
          end
        end
        RD: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d = RD_ACK;
              phase_d = 1'b0;
            end
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d   = ptr_adv;
              phase_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b0;
            end else begin
              state_d  = RD;
              phase_d  = 1'b0;
              bitcnt_d = '0;
              shift_d  = rd_bank[ptr_idx];
              sda_oe_d = ~rd_bank[ptr_idx][7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign SdaOe_o    = sda_oe_q;
  assign RegsWr_ob  = regs_q;
  assign WrStrobe_o = strobe_q;
  assign WrAddr_ob8 = wr_addr_q;
  assign Busy_o     = busy_q;

`ifdef I2C_TARGET_DEBUG_EN
  logic [7:0] addr_rx_q, ptr_rx_q;
  logic       byte_done;
  assign byte_done = ~start_det & ~stop_det & scl_rise & (bitcnt_q == 3'd7);

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      addr_rx_q <= '0;
      ptr_rx_q  <= '0;
    end else if (byte_done) begin
      if (state_q == ADDR && addr_match) addr_rx_q <= rx_byte;
      if (state_q == PTR && ptr_ok)      ptr_rx_q  <= rx_byte;
    end
  end

  assign State_o    = state_q;
  assign AddrRx_ob8 = addr_rx_q;
  assign PtrRx_ob8  = ptr_rx_q;
`endif
endmodule

// File: tb/tb_i2c_register_target.sv
// Bench for i2c_register_target: bit-banged I2C master, write/read scoreboards, register model.
module tb_i2c_register_target;
  localparam int NR = 16;
  localparam int Q  = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           scl_m = 1'b1;
  logic           sda_m = 1'b1;
  logic           sda_line;
  logic           sda_oe;
  logic [NR*8-1:0] regs_wr;
  logic [NR*8-1:0] regs_rd = '1;
  logic           wr_strobe;
  logic [7:0]     wr_addr;
  logic           busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_strobe = 0;
  logic prev_strobe = 1'b0;
  logic oe_seen = 1'b0;
  logic [NR-1:0][7:0] model = '0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_register_target #(.DEVICE_ADDR(7'h50), .NUM_REGS(NR), .FILTER_LEN(4), .AUTO_INC(1)) dut (
    .Clk_ik(clk), .Rst_irn(rst_n), .Scl_i(scl_m), .Sda_i(sda_line), .SdaOe_o(sda_oe),
    .RegsWr_ob(regs_wr), .RegsRd_ib(regs_rd), .WrStrobe_o(wr_strobe), .WrAddr_ob8(wr_addr),
    .Busy_o(busy));

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write scoreboard: every strobe must match the oldest pending expected write
  always @(negedge clk) begin
    if (sda_oe) oe_seen <= 1'b1;
    if (rst_n && wr_strobe) begin
      n_strobe++;
      check_eq("strobe_width", prev_strobe, 1'b0);
      check_eq("strobe_expected", exp_wr.size() != 0, 1'b1);
      if (exp_wr.size() != 0) begin
        logic [15:0] e;
        e = exp_wr.pop_front();
        check_eq("wr_addr", wr_addr, e[15:8]);
        check_eq("wr_data", regs_wr[e[15:8]*8 +: 8], e[7:0]);
      end
    end
    prev_strobe <= wr_strobe;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(2*Q);
    sda_m = 1'b0; wait_cyc(2*Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(2*Q);
    sda_m = 1'b1; wait_cyc(2*Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      wait_cyc(3);
      scl_m = 1'b1; wait_cyc(2);
      scl_m = 1'b0; wait_cyc(Q-5);
    end else begin
      wait_cyc(Q);
    end
    scl_m = 1'b1; wait_cyc(2*Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    b = sda_line; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], glitch);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack, 1'b0);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    model[a] = d;
  endtask

  initial begin
    logic ack;
    logic b;
    logic [7:0] d;
    int s0;

    wait_cyc(3);
    check_eq("rst_sda_oe", sda_oe, 1'b0);
    check_eq("rst_regs", regs_wr, '0);
    check_eq("rst_strobe", wr_strobe, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(10);

    // single write 0xA5 -> reg 3
    s0 = n_strobe;
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check_eq("w1_addr_ack", ack, 1'b0);
    check_eq("w1_busy", busy, 1'b1);
    write_byte(8'h03, 1'b0, ack); check_eq("w1_ptr_ack", ack, 1'b0);
    push_wr(8'd3, 8'hA5);
    write_byte(8'hA5, 1'b0, ack); check_eq("w1_data_ack", ack, 1'b0);
    i2c_stop();
    wait_cyc(5);
    check_eq("w1_reg3", regs_wr[31:24], 8'hA5);
    check_eq("w1_strobes", n_strobe - s0, 1);
    check_eq("w1_wr_addr", wr_addr, 8'd3);
    check_eq("w1_busy_clr", busy, 1'b0);

    // burst with wrap at NUM_REGS-1
    s0 = n_strobe;
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check_eq("b_addr_ack", ack, 1'b0);
    write_byte(8'h0E, 1'b0, ack); check_eq("b_ptr_ack", ack, 1'b0);
    push_wr(8'd14, 8'h11); write_byte(8'h11, 1'b0, ack); check_eq("b_d0_ack", ack, 1'b0);
    push_wr(8'd15, 8'h22); write_byte(8'h22, 1'b0, ack); check_eq("b_d1_ack", ack, 1'b0);
    push_wr(8'd0,  8'h33); write_byte(8'h33, 1'b0, ack); check_eq("b_d2_ack", ack, 1'b0);
    i2c_stop();
    wait_cyc(5);
    check_eq("b_strobes", n_strobe - s0, 3);
    check_eq("b_regs", regs_wr, model);

    // repeated-START read of regs 5/6
    regs_rd[5*8 +: 8] = 8'h5C;
    regs_rd[6*8 +: 8] = 8'h6D;
    regs_rd[2*8 +: 8] = 8'h00;
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check_eq("r_addr_ack", ack, 1'b0);
    write_byte(8'h05, 1'b0, ack); check_eq("r_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0, ack); check_eq("r_addr2_ack", ack, 1'b0);
    exp_rd.push_back(8'h5C);
    exp_rd.push_back(8'h6D);
    read_byte(1'b0, d);
    check_eq("r_q_nonempty0", exp_rd.size() != 0, 1'b1);
    if (exp_rd.size() != 0) check_eq("r_byte0", d, exp_rd.pop_front());
    read_byte(1'b1, d);
    check_eq("r_q_nonempty1", exp_rd.size() != 0, 1'b1);
    if (exp_rd.size() != 0) check_eq("r_byte1", d, exp_rd.pop_front());
    check_eq("r_sda_released", sda_oe, 1'b0);
    check_eq("r_busy_clr", busy, 1'b0);
    i2c_stop();
    wait_cyc(5);

    // wrong device address
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, 1'b0, ack); check_eq("na_nack", ack, 1'b1);
    write_byte(8'h04, 1'b0, ack); check_eq("na_ptr_nack", ack, 1'b1);
    i2c_stop();
    wait_cyc(5);
    check_eq("na_oe_never", oe_seen, 1'b0);
    check_eq("na_busy", busy, 1'b0);
    check_eq("na_regs", regs_wr, model);

    // out-of-range pointer
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check_eq("op_addr_ack", ack, 1'b0);
    write_byte(8'h20, 1'b0, ack); check_eq("op_ptr_nack", ack, 1'b1);
    write_byte(8'h77, 1'b0, ack); check_eq("op_data_nack", ack, 1'b1);
    i2c_stop();
    wait_cyc(5);
    check_eq("op_regs", regs_wr, model);

    // 2-cycle SCL glitches inside every low phase
    s0 = n_strobe;
    i2c_start();
    write_byte(8'hA0, 1'b1, ack); check_eq("g_addr_ack", ack, 1'b0);
    write_byte(8'h07, 1'b1, ack); check_eq("g_ptr_ack", ack, 1'b0);
    push_wr(8'd7, 8'h3C);
    write_byte(8'h3C, 1'b1, ack); check_eq("g_data_ack", ack, 1'b0);
    i2c_stop();
    wait_cyc(5);
    check_eq("g_strobes", n_strobe - s0, 1);
    check_eq("g_regs", regs_wr, model);

    // reset mid-read while the target drives SDA low
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check_eq("rr_addr_ack", ack, 1'b0);
    write_byte(8'h02, 1'b0, ack); check_eq("rr_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0, ack); check_eq("rr_addr2_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) read_bit(b);
    check_eq("rr_driving", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rr_sda_oe", sda_oe, 1'b0);
    check_eq("rr_regs", regs_wr, '0);
    check_eq("rr_busy", busy, 1'b0);
    check_eq("rr_wr_addr", wr_addr, 8'h00);
    model = '0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(10);
    rst_n = 1'b1;
    wait_cyc(20);

    // recovery after reset
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check_eq("rc_addr_ack", ack, 1'b0);
    write_byte(8'h01, 1'b0, ack); check_eq("rc_ptr_ack", ack, 1'b0);
    push_wr(8'd1, 8'h42);
    write_byte(8'h42, 1'b0, ack); check_eq("rc_data_ack", ack, 1'b0);
    i2c_stop();
    wait_cyc(5);
    check_eq("rc_regs", regs_wr, model);
    check_eq("wr_q_drained", exp_wr.size(), 0);
    check_eq("rd_q_drained", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
